// File: rtl/overlay_mem_writer.sv
// overlay_mem_writer
// Buffers 54-bit pixel write packets {mask[3:0], frame, addr[16:0], pixel[31:0]}
// in a FIFO and turns each into one masked burst write to the DDR2 controller:
// one command on the address FIFO (af_*) plus two 128-bit beats on the
// write-data FIFO (wdf_*).
//
// Ports:
//   clock, reset_n             system clock, asynchronous active-low reset
//   din, din_valid, din_ready  packet input (valid/ready handshake)
//   af_cmd_din, af_addr_din,   controller command push (always a write)
//   af_wr_en, af_full
//   wdf_din, wdf_mask_din,     controller write-data push (mask 1 = byte skipped)
//   wdf_wr_en, wdf_full
//   level                      packets currently buffered
//   idle                       FIFO empty and no burst in flight
module overlay_mem_writer #(
  parameter int unsigned DEPTH       = 16,
  parameter logic [30:0] FRAME0_BASE = 31'h0010_0000,
  parameter logic [30:0] FRAME1_BASE = 31'h0020_0000,
  localparam int unsigned AW         = $clog2(DEPTH),
  localparam int unsigned LW         = $clog2(DEPTH) + 1
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [53:0]    din,
  input  logic           din_valid,
  output logic           din_ready,
  output logic [2:0]     af_cmd_din,
  output logic [30:0]    af_addr_din,
  output logic           af_wr_en,
  input  logic           af_full,
  output logic [127:0]   wdf_din,
  output logic [15:0]    wdf_mask_din,
  output logic           wdf_wr_en,
  input  logic           wdf_full,
  output logic [LW-1:0]  level,
  output logic           idle
);

  typedef enum logic {
    S_IDLE,
    S_BEAT1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [53:0]   mem_q [DEPTH];

  logic          push, pop;
  logic [53:0]   head;
  logic [3:0]    head_mask;
  logic          head_frame;
  logic [16:0]   head_addr;
  logic [31:0]   head_pixel;
  logic [15:0]   sel_mask;
  logic [15:0]   beat0_mask, beat1_mask;
  logic [30:0]   burst_addr;

  // ---------------------------------------------------------------------------
  // Packet FIFO
  // ---------------------------------------------------------------------------
  // Full is judged on the registered count only, so a pop in the same cycle
  // never opens a slot for a push at full.
  assign din_ready = (level_q != LW'(DEPTH));
  assign push      = din_valid & din_ready;

  // NOTE: storage carries no reset; only pointers and count define which
  // entries are meaningful, so the array stays a plain RAM.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign head       = mem_q[rd_ptr_q];
  assign head_mask  = head[53:50];
  assign head_frame = head[49];
  assign head_addr  = head[48:32];
  assign head_pixel = head[31:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Burst formatting from the FIFO head
  // ---------------------------------------------------------------------------
  // Burst covers 8 words aligned on addr[16:3]; carries beyond 31 bits drop.
  assign burst_addr = (head_frame ? FRAME1_BASE : FRAME0_BASE)
                    + {14'd0, head_addr[16:3], 3'b000};

  // Only the addressed 32-bit lane of the addressed beat gets written; the
  // controller mask is inverted (1 = byte not written).
  always_comb begin
    sel_mask = '1;
    for (int w = 0; w < 4; w++) begin
      if (head_addr[1:0] == 2'(w)) sel_mask[4*w +: 4] = ~head_mask;
    end
  end

  assign beat0_mask = head_addr[2] ? 16'hFFFF : sel_mask;
  assign beat1_mask = head_addr[2] ? sel_mask : 16'hFFFF;

  // ---------------------------------------------------------------------------
  // Burst FSM
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    af_wr_en  = 1'b0;
    wdf_wr_en = 1'b0;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((level_q != '0) && !af_full && !wdf_full) begin
          af_wr_en  = 1'b1;
          wdf_wr_en = 1'b1;
          state_d   = S_BEAT1;
        end
      end
      S_BEAT1: begin
        // Head is retired only once its second beat is accepted.
        if (!wdf_full) begin
          wdf_wr_en = 1'b1;
          pop       = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Data outputs are zeroed while not pushing so stale or unwritten FIFO
  // entries never show on the controller bus.
  assign af_cmd_din   = 3'b000;
  assign af_addr_din  = af_wr_en ? burst_addr : '0;
  assign wdf_din      = wdf_wr_en ? {4{head_pixel}} : '0;
  assign wdf_mask_din = !wdf_wr_en          ? 16'h0000
                      : (state_q == S_IDLE) ? beat0_mask
                      :                       beat1_mask;

  assign level = level_q;
  assign idle  = (level_q == '0) && (state_q == S_IDLE);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: tb/tb_overlay_mem_writer.sv
// Directed testbench for overlay_mem_writer. Inputs change and outputs are
// sampled 1-2 time units after the rising edge, well clear of the next edge.
module tb_overlay_mem_writer;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [53:0]  din;
  logic         din_valid;
  logic         din_ready;
  logic [2:0]   af_cmd_din;
  logic [30:0]  af_addr_din;
  logic         af_wr_en;
  logic         af_full;
  logic [127:0] wdf_din;
  logic [15:0]  wdf_mask_din;
  logic         wdf_wr_en;
  logic         wdf_full;
  logic [4:0]   level;
  logic         idle;

  int checks = 0;
  int errors = 0;

  logic [53:0] pkts [16];

  always #5 clock = ~clock;

  overlay_mem_writer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .din          (din),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .af_cmd_din   (af_cmd_din),
    .af_addr_din  (af_addr_din),
    .af_wr_en     (af_wr_en),
    .af_full      (af_full),
    .wdf_din      (wdf_din),
    .wdf_mask_din (wdf_mask_din),
    .wdf_wr_en    (wdf_wr_en),
    .wdf_full     (wdf_full),
    .level        (level),
    .idle         (idle)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [53:0] mk(input logic [3:0] m, input logic f,
                                     input logic [16:0] a, input logic [31:0] p);
    return {m, f, a, p};
  endfunction

  // Reference model: base + 8-word aligned address; written lane mask built
  // by XOR-ing the shifted byte enables out of an all-ones word.
  function automatic logic [30:0] model_addr(input logic [53:0] pk);
    logic [30:0] base;
    base = pk[49] ? 31'h0020_0000 : 31'h0010_0000;
    return base + 31'(pk[48:32] & 17'h1FFF8);
  endfunction

  function automatic logic [15:0] model_mask(input logic [53:0] pk, input logic beat);
    if (pk[34] != beat) return 16'hFFFF;
    return 16'hFFFF ^ (16'(pk[53:50]) << (4 * int'(pk[33:32])));
  endfunction

  // Expects the DUT to be in the beat0 cycle of pk; consumes two cycles.
  task automatic expect_pkt(input string tag, input logic [53:0] pk);
    check({tag, "_b0_af_en"},  128'(af_wr_en),     128'(1));
    check({tag, "_b0_wdf_en"}, 128'(wdf_wr_en),    128'(1));
    check({tag, "_cmd"},       128'(af_cmd_din),   128'(0));
    check({tag, "_addr"},      128'(af_addr_din),  128'(model_addr(pk)));
    check({tag, "_b0_data"},   wdf_din,            {4{pk[31:0]}});
    check({tag, "_b0_mask"},   128'(wdf_mask_din), 128'(model_mask(pk, 1'b0)));
    step();
    check({tag, "_b1_af_en"},  128'(af_wr_en),     128'(0));
    check({tag, "_b1_wdf_en"}, 128'(wdf_wr_en),    128'(1));
    check({tag, "_b1_data"},   wdf_din,            {4{pk[31:0]}});
    check({tag, "_b1_mask"},   128'(wdf_mask_din), 128'(model_mask(pk, 1'b1)));
    step();
  endtask

  initial begin
    reset_n   = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    af_full   = 1'b0;
    wdf_full  = 1'b0;

    // ---- reset state
    #3;
    check("rst_din_ready", 128'(din_ready),    128'(1));
    check("rst_af_wr_en",  128'(af_wr_en),     128'(0));
    check("rst_wdf_wr_en", 128'(wdf_wr_en),    128'(0));
    check("rst_idle",      128'(idle),         128'(1));
    check("rst_level",     128'(level),        128'(0));
    check("rst_af_addr",   128'(af_addr_din),  128'(0));
    check("rst_wdf_din",   wdf_din,            128'(0));
    check("rst_wdf_mask",  128'(wdf_mask_din), 128'(0));
    step();
    step();
    reset_n = 1'b1;
    step();

    // ---- single packet, frame 0, hand-computed values
    din       = mk(4'b0010, 1'b0, 17'h00005, 32'h0202_0202);
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    #1;
    check("p1_level",    128'(level),        128'(1));
    check("p1_af_en",    128'(af_wr_en),     128'(1));
    check("p1_wdf_en",   128'(wdf_wr_en),    128'(1));
    check("p1_addr",     128'(af_addr_din),  128'(31'h0010_0000));
    check("p1_b0_mask",  128'(wdf_mask_din), 128'(16'hFFFF));
    check("p1_b0_data",  wdf_din,            128'h0202_0202_0202_0202_0202_0202_0202_0202);
    step();
    check("p1_b1_af_en", 128'(af_wr_en),     128'(0));
    check("p1_b1_wdf",   128'(wdf_wr_en),    128'(1));
    check("p1_b1_mask",  128'(wdf_mask_din), 128'(16'hFFDF));
    check("p1_b1_data",  wdf_din,            128'h0202_0202_0202_0202_0202_0202_0202_0202);
    step();
    check("p1_idle",     128'(idle),         128'(1));
    check("p1_level0",   128'(level),        128'(0));

    // ---- single packet, frame 1, top address
    din       = mk(4'b1000, 1'b1, 17'h1FFFF, 32'hA5A5_1234);
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    #1;
    check("p2_af_en",    128'(af_wr_en),     128'(1));
    check("p2_addr",     128'(af_addr_din),  128'(31'h0021_FFF8));
    check("p2_b0_mask",  128'(wdf_mask_din), 128'(16'hFFFF));
    step();
    check("p2_b1_mask",  128'(wdf_mask_din), 128'(16'h7FFF));
    check("p2_b1_data",  wdf_din,            {4{32'hA5A5_1234}});
    step();
    check("p2_idle",     128'(idle),         128'(1));

    // ---- af_full held: fill all 16 entries, then drain in order
    af_full = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pkts[i]   = mk(4'(i) ^ 4'h5, i[1], 17'(i * 8 + (i % 2) * 4 + (i % 4)),
                     32'h0101_0101 * 32'(i + 1));
      din       = pkts[i];
      din_valid = 1'b1;
      #1;
      check("fill_ready", 128'(din_ready), 128'(1));
      check("fill_af_en", 128'(af_wr_en),  128'(0));
      check("fill_wdf_en", 128'(wdf_wr_en), 128'(0));
      step();
    end
    din = mk(4'hF, 1'b0, 17'h0, 32'hDEAD_BEEF);
    #1;
    check("full_level",  128'(level),     128'(16));
    check("full_ready",  128'(din_ready), 128'(0));
    check("full_af_en",  128'(af_wr_en),  128'(0));
    check("full_wdf_en", 128'(wdf_wr_en), 128'(0));
    step();
    check("full_no_push", 128'(level),    128'(16));
    din_valid = 1'b0;
    af_full   = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      expect_pkt($sformatf("drain%0d", i), pkts[i]);
    end
    check("drain_idle",  128'(idle),  128'(1));
    check("drain_level", 128'(level), 128'(0));

    // ---- wdf_full stalls beat1
    din       = mk(4'b0001, 1'b0, 17'h00006, 32'h1357_9BDF);
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    #1;
    check("st_b0_wdf_en", 128'(wdf_wr_en), 128'(1));
    step();
    wdf_full = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("st_wdf_en", 128'(wdf_wr_en), 128'(0));
      check("st_af_en",  128'(af_wr_en),  128'(0));
      check("st_level",  128'(level),     128'(1));
      step();
    end
    wdf_full = 1'b0;
    #1;
    check("st_b1_wdf_en", 128'(wdf_wr_en),    128'(1));
    check("st_b1_mask",   128'(wdf_mask_din), 128'(16'hFEFF));
    check("st_b1_data",   wdf_din,            {4{32'h1357_9BDF}});
    step();
    check("st_level0",    128'(level),        128'(0));
    check("st_idle",      128'(idle),         128'(1));

    // ---- push and pop together at DEPTH-1, and no push at full
    af_full = 1'b1;
    for (int i = 0; i < 15; i++) begin
      din       = mk(4'h3, 1'b0, 17'(i * 8), 32'(i));
      din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0;
    af_full   = 1'b0;
    #1;
    check("pp_level15",  128'(level),     128'(15));
    check("pp_b0_af_en", 128'(af_wr_en),  128'(1));
    step();
    din       = mk(4'h3, 1'b0, 17'h100, 32'h0000_0F0F);
    din_valid = 1'b1;
    #1;
    check("pp_ready",    128'(din_ready), 128'(1));
    check("pp_pop",      128'(wdf_wr_en), 128'(1));
    step();
    check("pp_level_same", 128'(level),   128'(15));
    check("pp_ready2",   128'(din_ready), 128'(1));
    step();
    check("pf_level16",  128'(level),     128'(16));
    check("pf_ready",    128'(din_ready), 128'(0));
    check("pf_pop",      128'(wdf_wr_en), 128'(1));
    step();
    check("pf_level15",  128'(level),     128'(15));
    din_valid = 1'b0;
    for (int k = 0; k < 200 && !idle; k++) step();
    check("pp_drain_idle", 128'(idle),    128'(1));

    // ---- reset in the middle of a burst
    din       = mk(4'h0, 1'b1, 17'h00004, 32'hCAFE_F00D);
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    check("rb_in_beat1", 128'(wdf_wr_en), 128'(1));
    reset_n = 1'b0;
    #1;
    check("rb_idle",     128'(idle),      128'(1));
    check("rb_level",    128'(level),     128'(0));
    check("rb_af_en",    128'(af_wr_en),  128'(0));
    check("rb_wdf_en",   128'(wdf_wr_en), 128'(0));
    step();
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rb_post_wdf_en", 128'(wdf_wr_en), 128'(0));
      check("rb_post_af_en",  128'(af_wr_en),  128'(0));
      check("rb_post_idle",   128'(idle),      128'(1));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
